// File: rtl/img_buf_scanout.sv
// img_buf_scanout: prefetches image-buffer rows into ping-pong banks and streams them as a valid/ready pixel stream
module img_buf_scanout #(
  parameter int PIX_W   = 12,
  parameter int ROW_PIX = 256,
  parameter int ROWS    = 256,
  parameter int ADDR_W  = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       img_idx,
  output logic                       re,
  output logic [ADDR_W:0]            raddr,
  input  logic [PIX_W*ROW_PIX-1:0]   rdata_in,
  output logic [PIX_W-1:0]           pix_out,
  output logic                       pix_vld,
  input  logic                       pix_rdy,
  output logic [$clog2(ROW_PIX)-1:0] pix_col,
  output logic [ADDR_W-1:0]          pix_row,
  output logic                       busy,
  output logic                       frame_done
);
  localparam int ROW_W = PIX_W * ROW_PIX;
  localparam int CW    = $clog2(ROW_PIX);
  localparam int IW    = $clog2(ROW_W);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic idx_q, idx_d, cur_q, cur_d, fill_q, fill_d, rv_q, rv_d;
  logic [ADDR_W:0] fetch_row_q, fetch_row_d, raddr_q, raddr_d;
  logic [ADDR_W-1:0] out_row_q, out_row_d, pix_row_q, pix_row_d;
  logic [CW-1:0] col_q, col_d, pix_col_q, pix_col_d;
  logic [1:0] full_q, full_d;
  logic [ROW_W-1:0] bank0_q, bank0_d, bank1_q, bank1_d, sel;
  logic [PIX_W-1:0] pix_out_q, pix_out_d;
  logic re_q, re_d, pix_vld_q, pix_vld_d, busy_q, busy_d, done_q, done_d;
  logic capture, xfer, last_col, last_row, can_fetch;
  logic [IW-1:0] off;
  assign re         = re_q;
  assign raddr      = raddr_q;
  assign pix_out    = pix_out_q;
  assign pix_vld    = pix_vld_q;
  assign pix_col    = pix_col_q;
  assign pix_row    = pix_row_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  // Next state: one read in flight at a time, fill the idle bank, stream from cur; outputs derive from next state
  always_comb begin
    capture     = state_q == RUN && rv_q;
    xfer        = pix_vld_q && pix_rdy;
    last_col    = col_q == CW'(ROW_PIX - 1);
    last_row    = out_row_q == ADDR_W'(ROWS - 1);
    can_fetch   = state_q == RUN && !(&full_q) && fetch_row_q < (ADDR_W+1)'(ROWS) && !re_q && !rv_q;
    state_d     = state_q;
    idx_d       = idx_q;
    cur_d       = cur_q;
    fill_d      = fill_q;
    rv_d        = re_q;
    fetch_row_d = fetch_row_q;
    raddr_d     = raddr_q;
    out_row_d   = out_row_q;
    col_d       = col_q;
    full_d      = full_q;
    re_d        = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;
    bank0_d     = capture && !fill_q ? rdata_in : bank0_q;
    bank1_d     = capture && fill_q ? rdata_in : bank1_q;
    unique case (state_q)
      IDLE: if (start) begin
        state_d     = RUN;
        idx_d       = img_idx;
        fetch_row_d = '0;
        out_row_d   = '0;
        col_d       = '0;
        cur_d       = 1'b0;
        fill_d      = 1'b0;
        full_d      = '0;
        busy_d      = 1'b1;
        re_d        = 1'b1;
        raddr_d     = {img_idx, ADDR_W'(0)};
      end
      RUN: begin
        if (can_fetch) begin
          re_d    = 1'b1;
          raddr_d = {idx_q, fetch_row_q[ADDR_W-1:0]};
          fill_d  = full_q[cur_q] ? ~cur_q : cur_q;
        end
        if (xfer && last_col) full_d[cur_q] = 1'b0;
        if (capture) begin
          full_d[fill_q] = 1'b1;
          fetch_row_d    = fetch_row_q + (ADDR_W+1)'(1);
        end
        if (xfer) begin
          col_d = last_col ? '0 : col_q + CW'(1);
          if (last_col && last_row) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else if (last_col) begin
            cur_d     = ~cur_q;
            out_row_d = out_row_q + ADDR_W'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    sel       = cur_d ? bank1_d : bank0_d;
    off       = IW'(col_d) * IW'(PIX_W);
    pix_vld_d = state_d == RUN && full_d[cur_d];
    pix_out_d = sel[off +: PIX_W];
    pix_col_d = col_d;
    pix_row_d = out_row_d;
  end
  // State and registered outputs, cleared asynchronously so a reset aborts a frame at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= 1'b0;
      cur_q       <= 1'b0;
      fill_q      <= 1'b0;
      rv_q        <= 1'b0;
      fetch_row_q <= '0;
      raddr_q     <= '0;
      out_row_q   <= '0;
      col_q       <= '0;
      full_q      <= '0;
      bank0_q     <= '0;
      bank1_q     <= '0;
      re_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pix_vld_q   <= 1'b0;
      pix_out_q   <= '0;
      pix_col_q   <= '0;
      pix_row_q   <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cur_q       <= cur_d;
      fill_q      <= fill_d;
      rv_q        <= rv_d;
      fetch_row_q <= fetch_row_d;
      raddr_q     <= raddr_d;
      out_row_q   <= out_row_d;
      col_q       <= col_d;
      full_q      <= full_d;
      bank0_q     <= bank0_d;
      bank1_q     <= bank1_d;
      re_q        <= re_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pix_vld_q   <= pix_vld_d;
      pix_out_q   <= pix_out_d;
      pix_col_q   <= pix_col_d;
      pix_row_q   <= pix_row_d;
    end
  end
endmodule

// File: tb/tb_img_buf_scanout.sv
// tb_img_buf_scanout: scoreboard bench for the row-prefetching pixel scanout
module tb_img_buf_scanout;
  logic clk = 1'b0, rst_n, start, img_idx, re, pix_vld, pix_rdy, busy, frame_done;
  logic [8:0] raddr;
  logic [3071:0] rdata_in = '0;
  logic [11:0] pix_out;
  logic [7:0] pix_col, pix_row;
  typedef struct packed {logic [7:0] row; logic [7:0] col; logic [11:0] pix;} exp_t;
  exp_t sb[$];
  logic [8:0] rd_log[$];
  int tests = 0, fails = 0, xfers = 0, done_cnt = 0, rd_cnt = 0, gaps = 0;
  logic nogap = 1'b0, exp_msb = 1'b0, hold_q = 1'b0;
  logic [11:0] hold_pix = '0;

  img_buf_scanout dut (
    .clk(clk), .rst_n(rst_n), .start(start), .img_idx(img_idx), .re(re), .raddr(raddr),
    .rdata_in(rdata_in), .pix_out(pix_out), .pix_vld(pix_vld), .pix_rdy(pix_rdy),
    .pix_col(pix_col), .pix_row(pix_row), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] pat(logic img, int r, int c);
    return 12'((r + c + (img ? 2048 : 0)) & 4095);
  endfunction

  function automatic logic [3071:0] mk_row(logic img, int r);
    logic [3071:0] d;
    for (int c = 0; c < 256; c++) d[c*12 +: 12] = pat(img, r, c);
    return d;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset();
    chk("rst_re", re, 0);
    chk("rst_raddr", raddr, 0);
    chk("rst_vld", pix_vld, 0);
    chk("rst_pix", pix_out, 0);
    chk("rst_col", pix_col, 0);
    chk("rst_row", pix_row, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", frame_done, 0);
  endtask

  // image buffer: data valid exactly one cycle after re, zero otherwise
  always @(posedge clk) rdata_in <= re ? mk_row(raddr[8], int'(raddr[7:0])) : '0;

  // monitor: pops the scoreboard on each transfer, checks hold stability and read bounds
  initial forever begin
    @(negedge clk);
    if (!rst_n) hold_q = 1'b0;
    else begin
      if (hold_q) begin
        chk("hold_vld", pix_vld, 1);
        chk("hold_pix", pix_out, hold_pix);
      end
      hold_q = pix_vld & ~pix_rdy;
      hold_pix = pix_out;
      if (pix_vld && pix_rdy) begin
        xfers++;
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_xfer: got row %0d col %0d pix %0h expected none", pix_row, pix_col, pix_out);
        end else chk("pixel {row,col,pix}", {pix_row, pix_col, pix_out}, sb.pop_front());
      end
      if (nogap && !pix_vld && !frame_done) gaps++;
      if (frame_done) done_cnt++;
      if (re) begin
        rd_cnt++;
        rd_log.push_back(raddr);
        chk("rd_msb", raddr[8], exp_msb);
        chk("rd_ahead", int'(raddr[7:0]) <= int'(pix_row) + 1, 1);
      end
    end
  end

  // pulse start for an idle DUT and check the fill latency cycle by cycle
  task automatic start_frame(logic img);
    @(posedge clk); #1;
    for (int r = 0; r < 256; r++)
      for (int c = 0; c < 256; c++) sb.push_back({8'(r), 8'(c), pat(img, r, c)});
    exp_msb = img;
    rd_cnt = 0;
    rd_log.delete();
    start = 1'b1;
    img_idx = img;
    @(negedge clk);
    chk("c0_re", re, 0);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("c1_re", re, 1);
    chk("c1_raddr", raddr, {img, 8'd0});
    chk("c1_busy", busy, 1);
    @(negedge clk);
    chk("c2_vld", pix_vld, 0);
    @(negedge clk);
    chk("c3_vld", pix_vld, 1);
    chk("c3_col", pix_col, 0);
    chk("c3_row", pix_row, 0);
    chk("c3_pix", pix_out, pat(img, 0, 0));
  endtask

  initial begin
    repeat (120000) @(posedge clk);
    $display("FAIL watchdog: got no finish expected finish within 120000 cycles");
    $fatal(1, "watchdog");
  end

  initial begin
    int sw, r2, dc;
    bit found;
    rst_n = 1'b0;
    start = 1'b0;
    img_idx = 1'b0;
    pix_rdy = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    // full frame, always ready: pattern, no gaps, single frame_done
    pix_rdy = 1'b1;
    xfers = 0;
    start_frame(1'b0);
    nogap = 1'b1;
    for (int i = 0; i < 70000 && !frame_done; i++) @(negedge clk);
    nogap = 1'b0;
    chk("frameA_done", frame_done, 1);
    chk("frameA_vld_in_done", pix_vld, 0);
    chk("frameA_xfers", xfers, 65536);
    chk("frameA_gaps", gaps, 0);
    chk("frameA_reads", rd_cnt, 256);
    chk("frameA_sb_left", sb.size(), 0);
    repeat (3) @(negedge clk);
    chk("frameA_done_cnt", done_cnt, 1);
    chk("frameA_busy", busy, 0);
    // image 1 start, then stall the consumer: only rows 0 and 1 fetched
    start_frame(1'b1);
    @(posedge clk); #1;
    pix_rdy = 1'b0;
    repeat (1000) @(negedge clk);
    chk("stall_reads", rd_cnt, 2);
    chk("stall_rd0", rd_log[0], 9'h100);
    chk("stall_rd1", rd_log[1], 9'h101);
    chk("stall_busy", busy, 1);
    @(posedge clk); #1;
    pix_rdy = 1'b1;
    sw = -1;
    r2 = -1;
    for (int i = 0; i < 600 && (sw < 0 || r2 < 0); i++) begin
      @(negedge clk);
      if (sw < 0 && pix_row == 8'd1) sw = i;
      if (r2 < 0 && re && raddr[7:0] == 8'd2) r2 = i;
    end
    chk("row2_after_switch", sw >= 0 && r2 >= sw && r2 - sw <= 2, 1);
    // second start mid-frame with flipped index is ignored
    @(posedge clk); #1;
    start = 1'b1;
    img_idx = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("restart_busy", busy, 1);
    // random backpressure
    repeat (700) begin
      @(posedge clk); #1;
      pix_rdy = 1'($urandom_range(0, 1));
    end
    pix_rdy = 1'b1;
    // reset mid-frame at row 100 col 37
    found = 1'b0;
    for (int i = 0; i < 40000; i++) begin
      @(posedge clk); #1;
      if (pix_vld && pix_row == 8'd100 && pix_col == 8'd37) begin
        found = 1'b1;
        break;
      end
    end
    chk("reach_row100_col37", found, 1);
    dc = done_cnt;
    rst_n = 1'b0;
    #1;
    chk_reset();
    repeat (3) @(negedge clk);
    chk("abort_no_done", done_cnt, dc);
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    start_frame(1'b0);
    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
